// File: rtl/ahb_slave_mem_if.sv
// AHB slave-side bus bundle for the on-chip word memory.
// The master modport is the bus side that drives transfers; the slave modport is the memory.
interface ahb_slave_mem_if;
  logic        hsel;
  logic [31:0] haddr;
  logic        hwrite;
  logic [1:0]  htrans;
  logic [31:0] hwdata;
  logic        hready_in;
  logic [31:0] hrdata;
  logic        hready_out;
  logic [1:0]  hresp;

  modport master (
    output hsel, haddr, hwrite, htrans, hwdata, hready_in,
    input  hrdata, hready_out, hresp
  );

  modport slave (
    input  hsel, haddr, hwrite, htrans, hwdata, hready_in,
    output hrdata, hready_out, hresp
  );
endinterface

// File: rtl/ahb_slave_mem.sv
// Word-addressed AHB slave memory with a fixed number of wait states per OKAY transfer
// and a two-cycle ERROR response for misaligned or out-of-range accesses.
//
// state | meaning
// IDLE  | no data phase in progress, ready to accept
// WAIT  | OKAY data phase being stretched, counter running down
// LAST  | final OKAY data-phase cycle; read data valid, write commits at its end
// ERR1  | first ERROR cycle (hready_out low)
// ERR2  | second ERROR cycle (hready_out high)
module ahb_slave_mem #(
  parameter int DEPTH       = 256,
  parameter int AW          = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic           hclk,
  input  logic           hreset,
  ahb_slave_mem_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_LAST,
    S_ERR1,
    S_ERR2
  } state_t;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t          r_state;
  logic [3:0]      r_cnt;
  logic [AW-1:0]   r_addr;
  logic            r_write;
  logic            r_hready_out;
  logic [1:0]      r_hresp;
  logic [31:0]     r_hrdata;
  logic [31:0]     r_mem [0:DEPTH-1];

  logic            w_accept;
  logic            w_err;
  logic [AW-1:0]   w_addr;
  logic            w_commit;
  logic            w_rd_load;
  logic [AW-1:0]   w_rd_addr;
  logic [31:0]     w_rd_data;
  logic            w_unused;

  assign w_unused = bus.htrans[0];

  // Accept only while our own data phase is in a ready cycle, so a misbehaving
  // bus-level hready cannot cut a wait or error sequence short.
  assign w_accept = bus.hsel & bus.hready_in & bus.htrans[1] & r_hready_out;
  assign w_err    = (bus.haddr[1:0] != 2'b00) | (|bus.haddr[31:AW+2]);
  assign w_addr   = bus.haddr[AW+1:2];

  // A pending write lands on the edge that leaves LAST.
  assign w_commit = (r_state == S_LAST) & r_write;

  // Reads enter LAST either from the end of WAIT or straight from an accept
  // when there are no wait states.
  assign w_rd_load = ((r_state == S_WAIT) && (r_cnt == 4'd1) && !r_write) ||
                     (w_accept && !w_err && (WS == 4'd0) && !bus.hwrite);
  assign w_rd_addr = (r_state == S_WAIT) ? r_addr : w_addr;

  // Forward the committing write so a zero-wait read right behind it is not stale.
  assign w_rd_data = (w_commit && (r_addr == w_rd_addr)) ? bus.hwdata : r_mem[w_rd_addr];

  assign bus.hready_out = r_hready_out;
  assign bus.hresp      = r_hresp;
  assign bus.hrdata     = r_hrdata;

  // Transfer FSM: state, wait counter, latched address phase and registered outputs.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_addr       <= '0;
      r_write      <= 1'b0;
      r_hready_out <= 1'b1;
      r_hresp      <= 2'b00;
      r_hrdata     <= 32'd0;
    end else begin
      if (w_rd_load) begin
        r_hrdata <= w_rd_data;
      end
      case (r_state)
        S_WAIT: begin
          if (r_cnt == 4'd1) begin
            r_state      <= S_LAST;
            r_cnt        <= 4'd0;
            r_hready_out <= 1'b1;
            r_hresp      <= 2'b00;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_ERR1: begin
          r_state      <= S_ERR2;
          r_hready_out <= 1'b1;
          r_hresp      <= 2'b01;
        end
        default: begin
          if (w_accept) begin
            r_addr  <= w_addr;
            // An errored write is dropped here so it can never reach memory.
            r_write <= bus.hwrite & ~w_err;
            if (w_err) begin
              r_state      <= S_ERR1;
              r_hready_out <= 1'b0;
              r_hresp      <= 2'b01;
            end else if (WS == 4'd0) begin
              r_state      <= S_LAST;
              r_hready_out <= 1'b1;
              r_hresp      <= 2'b00;
            end else begin
              r_state      <= S_WAIT;
              r_cnt        <= WS;
              r_hready_out <= 1'b0;
              r_hresp      <= 2'b00;
            end
          end else begin
            r_state      <= S_IDLE;
            r_write      <= 1'b0;
            r_hready_out <= 1'b1;
            r_hresp      <= 2'b00;
          end
        end
      endcase
    end
  end

  // Memory array; not reset, and a reset edge discards any pending write.
  always_ff @(posedge hclk) begin
    if (w_commit && !hreset) begin
      r_mem[r_addr] <= bus.hwdata;
    end
  end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench for ahb_slave_mem: three instances with 1, 0 and 3 wait states
// share one set of bus drives; hsel is steered to the instance under test.
module tb_ahb_slave_mem;

  logic        clk;
  logic        rst;
  logic        hsel;
  logic [31:0] haddr;
  logic        hwrite;
  logic [1:0]  htrans;
  logic [31:0] hwdata;
  logic        hready_in;
  logic [1:0]  cur;
  logic        o_rdy;
  logic [1:0]  o_resp;
  logic [31:0] o_rdata;
  int          checks;
  int          failures;

  ahb_slave_mem_if if0 ();
  ahb_slave_mem_if if1 ();
  ahb_slave_mem_if if2 ();

  assign if0.hsel = hsel && (cur == 2'd0);
  assign if1.hsel = hsel && (cur == 2'd1);
  assign if2.hsel = hsel && (cur == 2'd2);
  assign if0.haddr = haddr;      assign if1.haddr = haddr;      assign if2.haddr = haddr;
  assign if0.hwrite = hwrite;    assign if1.hwrite = hwrite;    assign if2.hwrite = hwrite;
  assign if0.htrans = htrans;    assign if1.htrans = htrans;    assign if2.htrans = htrans;
  assign if0.hwdata = hwdata;    assign if1.hwdata = hwdata;    assign if2.hwdata = hwdata;
  assign if0.hready_in = hready_in;
  assign if1.hready_in = hready_in;
  assign if2.hready_in = hready_in;

  assign o_rdy   = (cur == 2'd0) ? if0.hready_out : (cur == 2'd1) ? if1.hready_out : if2.hready_out;
  assign o_resp  = (cur == 2'd0) ? if0.hresp      : (cur == 2'd1) ? if1.hresp      : if2.hresp;
  assign o_rdata = (cur == 2'd0) ? if0.hrdata     : (cur == 2'd1) ? if1.hrdata     : if2.hrdata;

  ahb_slave_mem #(.DEPTH(256), .AW(8), .WAIT_STATES(1)) u_ws1 (.hclk(clk), .hreset(rst), .bus(if0.slave));
  ahb_slave_mem #(.DEPTH(256), .AW(8), .WAIT_STATES(0)) u_ws0 (.hclk(clk), .hreset(rst), .bus(if1.slave));
  ahb_slave_mem #(.DEPTH(256), .AW(8), .WAIT_STATES(3)) u_ws3 (.hclk(clk), .hreset(rst), .bus(if2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic w);
    hsel   = 1'b1;
    haddr  = a;
    hwrite = w;
    htrans = 2'b10;
  endtask

  task automatic bus_idle();
    hsel   = 1'b0;
    htrans = 2'b00;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic rdy, input logic [1:0] resp);
    chk({tag, "_rdy"}, {31'd0, o_rdy}, {31'd0, rdy});
    chk({tag, "_resp"}, {30'd0, o_resp}, {30'd0, resp});
  endtask

  // Linear directed sequence.
  initial begin
    checks = 0;
    failures = 0;
    cur = 2'd0;
    rst = 1'b1;
    hready_in = 1'b1;
    haddr = 32'd0;
    hwrite = 1'b0;
    hwdata = 32'd0;
    bus_idle();
    step();
    step();
    rst = 1'b0;
    chk_bus("reset", 1'b1, 2'b00);
    chk("reset_rdata", o_rdata, 32'd0);

    // WS=1: write 0x10, read it back back-to-back
    addr_phase(32'h10, 1'b1);
    step();
    chk_bus("wr10_wait", 1'b0, 2'b00);
    bus_idle();
    hwdata = 32'hDEADBEEF;
    step();
    chk_bus("wr10_last", 1'b1, 2'b00);
    addr_phase(32'h10, 1'b0);
    step();
    chk_bus("rd10_wait", 1'b0, 2'b00);
    bus_idle();
    hwdata = 32'h0;
    step();
    chk_bus("rd10_last", 1'b1, 2'b00);
    chk("rd10_data", o_rdata, 32'hDEADBEEF);
    step();
    chk_bus("rd10_idle", 1'b1, 2'b00);
    chk("rd10_hold", o_rdata, 32'hDEADBEEF);

    // WS=0: write 0x20 then immediately read it (forwarding)
    cur = 2'd1;
    addr_phase(32'h20, 1'b1);
    step();
    chk_bus("ws0_wr_last", 1'b1, 2'b00);
    hwdata = 32'h12345678;
    addr_phase(32'h20, 1'b0);
    step();
    chk_bus("ws0_rd_last", 1'b1, 2'b00);
    chk("ws0_fwd", o_rdata, 32'h12345678);
    bus_idle();
    hwdata = 32'h0;
    step();
    addr_phase(32'h20, 1'b0);
    step();
    chk("ws0_mem", o_rdata, 32'h12345678);
    bus_idle();
    step();

    // WS=1: seed word 0, then out-of-range and misaligned writes
    cur = 2'd0;
    addr_phase(32'h0, 1'b1);
    step();
    bus_idle();
    hwdata = 32'h11111111;
    step();
    addr_phase(32'h400, 1'b1);
    step();
    chk_bus("oor_err1", 1'b0, 2'b01);
    bus_idle();
    hwdata = 32'hBAD0BAD0;
    step();
    chk_bus("oor_err2", 1'b1, 2'b01);
    chk("oor_rdata", o_rdata, 32'hDEADBEEF);
    addr_phase(32'h2, 1'b1);
    step();
    chk_bus("mis_err1", 1'b0, 2'b01);
    bus_idle();
    step();
    chk_bus("mis_err2", 1'b1, 2'b01);
    step();
    chk_bus("err_idle", 1'b1, 2'b00);
    addr_phase(32'h0, 1'b0);
    step();
    bus_idle();
    step();
    chk("rd0_after_err", o_rdata, 32'h11111111);
    addr_phase(32'h13, 1'b0);
    step();
    chk_bus("misrd_err1", 1'b0, 2'b01);
    bus_idle();
    step();
    chk_bus("misrd_err2", 1'b1, 2'b01);
    chk("misrd_hold", o_rdata, 32'h11111111);
    step();

    // Ignored address phases: BUSY, hsel low, hready_in low
    hwdata = 32'hCAFEF00D;
    addr_phase(32'h0, 1'b1);
    htrans = 2'b01;
    step();
    chk_bus("ign_busy", 1'b1, 2'b00);
    step();
    chk_bus("ign_busy2", 1'b1, 2'b00);
    addr_phase(32'h0, 1'b1);
    hsel = 1'b0;
    step();
    chk_bus("ign_nosel", 1'b1, 2'b00);
    step();
    addr_phase(32'h0, 1'b1);
    hready_in = 1'b0;
    step();
    chk_bus("ign_nordy", 1'b1, 2'b00);
    step();
    hready_in = 1'b1;
    addr_phase(32'h0, 1'b0);
    step();
    bus_idle();
    step();
    chk("rd0_after_ign", o_rdata, 32'h11111111);
    step();

    // Reset during the WAIT of a write to 0x30
    addr_phase(32'h30, 1'b1);
    step();
    bus_idle();
    hwdata = 32'h5A5A5A5A;
    step();
    step();
    addr_phase(32'h30, 1'b1);
    step();
    chk_bus("rst_wait", 1'b0, 2'b00);
    bus_idle();
    hwdata = 32'hA5A5A5A5;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_bus("rst_out", 1'b1, 2'b00);
    chk("rst_rdata", o_rdata, 32'd0);
    step();
    chk_bus("rst_idle", 1'b1, 2'b00);
    addr_phase(32'h30, 1'b0);
    step();
    bus_idle();
    step();
    chk("rd30_old", o_rdata, 32'h5A5A5A5A);
    step();

    // WS=3: last word 0x3FC
    cur = 2'd2;
    addr_phase(32'h3FC, 1'b1);
    step();
    bus_idle();
    hwdata = 32'h0BADF00D;
    step();
    step();
    step();
    chk_bus("ws3_wr_last", 1'b1, 2'b00);
    step();
    hwdata = 32'h0;
    addr_phase(32'h3FC, 1'b0);
    step();
    chk_bus("ws3_w1", 1'b0, 2'b00);
    bus_idle();
    step();
    chk_bus("ws3_w2", 1'b0, 2'b00);
    step();
    chk_bus("ws3_w3", 1'b0, 2'b00);
    step();
    chk_bus("ws3_last", 1'b1, 2'b00);
    chk("ws3_data", o_rdata, 32'h0BADF00D);
    step();
    chk_bus("ws3_idle", 1'b1, 2'b00);
    chk("ws3_hold", o_rdata, 32'h0BADF00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
